// File: rtl/ring_node.sv
// ring_node: one stop on a unidirectional packet ring.
// Ring traffic addressed to this cell is delivered locally; other ring traffic
// is forwarded with strict priority. Local migrants wait in a small FIFO and
// are injected into the ring whenever the ring slot is free.
module ring_node #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [32:0] cell_id,
    input  logic [96:0] loc_pos_in,
    input  logic [96:0] loc_vel_in,
    input  logic [32:0] loc_cell_in,
    input  logic [96:0] ring_pos_in,
    input  logic [96:0] ring_vel_in,
    input  logic [32:0] ring_cell_in,
    output logic [96:0] ring_pos_out,
    output logic [96:0] ring_vel_out,
    output logic [32:0] ring_cell_out,
    output logic [96:0] dlv_pos,
    output logic [96:0] dlv_vel,
    output logic [32:0] dlv_cell,
    output logic        full,
    output logic        idle,
    output logic        overflow,
    output logic [15:0] dlv_cnt
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [96:0]   NULL_W  = {1'b1, 96'd0};
    localparam logic [32:0]   NULL_C  = {1'b1, 32'd0};
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // FIFO storage (payload only, no reset needed)
    logic [96:0] pos_mem_q  [FIFO_DEPTH];
    logic [96:0] vel_mem_q  [FIFO_DEPTH];
    logic [32:0] cell_mem_q [FIFO_DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [96:0]   ring_pos_q, ring_pos_d, ring_vel_q, ring_vel_d;
    logic [32:0]   ring_cell_q, ring_cell_d;
    logic [96:0]   dlv_pos_q, dlv_pos_d, dlv_vel_q, dlv_vel_d;
    logic [32:0]   dlv_cell_q, dlv_cell_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   dlv_cnt_q, dlv_cnt_d;

    logic loc_valid, ring_valid, ring_dlv, ring_fwd;
    logic push, pop, drop, fifo_full, fifo_empty;

    // Packet validity: any null field makes the whole packet null.
    assign loc_valid  = !loc_pos_in[96] && !loc_vel_in[96] && !loc_cell_in[32];
    assign ring_valid = !ring_pos_in[96] && !ring_vel_in[96] && !ring_cell_in[32];
    assign ring_dlv   = ring_valid && (ring_cell_in == cell_id);
    assign ring_fwd   = ring_valid && (ring_cell_in != cell_id);

    assign fifo_full  = (count_q == DEPTH_C);
    assign fifo_empty = (count_q == {CW{1'b0}});
    // Injection only when the ring slot is free; a full FIFO drops even if popping.
    assign pop        = !ring_fwd && !fifo_empty;
    assign push       = loc_valid && !fifo_full;
    assign drop       = loc_valid && fifo_full;

    // Next-state: ring/deliver output selection, FIFO bookkeeping, status.
    always_comb begin
        ring_pos_d  = NULL_W;
        ring_vel_d  = NULL_W;
        ring_cell_d = NULL_C;
        if (ring_fwd) begin
            ring_pos_d  = ring_pos_in;
            ring_vel_d  = ring_vel_in;
            ring_cell_d = ring_cell_in;
        end else if (pop) begin
            ring_pos_d  = pos_mem_q[rd_ptr_q];
            ring_vel_d  = vel_mem_q[rd_ptr_q];
            ring_cell_d = cell_mem_q[rd_ptr_q];
        end else begin
            ring_cell_d = NULL_C;
        end

        dlv_pos_d  = NULL_W;
        dlv_vel_d  = NULL_W;
        dlv_cell_d = NULL_C;
        dlv_cnt_d  = dlv_cnt_q;
        if (ring_dlv) begin
            dlv_pos_d  = ring_pos_in;
            dlv_vel_d  = ring_vel_in;
            dlv_cell_d = ring_cell_in;
            dlv_cnt_d  = dlv_cnt_q + 16'd1;
        end else begin
            dlv_cnt_d  = dlv_cnt_q;
        end

        wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q | drop;
    end

    // State registers with synchronous reset clearing all in-flight packets.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= {CW{1'b0}};
            ring_pos_q  <= NULL_W;
            ring_vel_q  <= NULL_W;
            ring_cell_q <= NULL_C;
            dlv_pos_q   <= NULL_W;
            dlv_vel_q   <= NULL_W;
            dlv_cell_q  <= NULL_C;
            overflow_q  <= 1'b0;
            dlv_cnt_q   <= 16'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ring_pos_q  <= ring_pos_d;
            ring_vel_q  <= ring_vel_d;
            ring_cell_q <= ring_cell_d;
            dlv_pos_q   <= dlv_pos_d;
            dlv_vel_q   <= dlv_vel_d;
            dlv_cell_q  <= dlv_cell_d;
            overflow_q  <= overflow_d;
            dlv_cnt_q   <= dlv_cnt_d;
        end
    end

    // FIFO payload write; gated off during reset so no stale push lands.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pos_mem_q[wr_ptr_q]  <= loc_pos_in;
            vel_mem_q[wr_ptr_q]  <= loc_vel_in;
            cell_mem_q[wr_ptr_q] <= loc_cell_in;
        end
    end

    assign ring_pos_out  = ring_pos_q;
    assign ring_vel_out  = ring_vel_q;
    assign ring_cell_out = ring_cell_q;
    assign dlv_pos       = dlv_pos_q;
    assign dlv_vel       = dlv_vel_q;
    assign dlv_cell      = dlv_cell_q;
    assign overflow      = overflow_q;
    assign dlv_cnt       = dlv_cnt_q;
    assign full          = fifo_full;
    assign idle          = fifo_empty && ring_cell_in[32] && ring_cell_q[32] && dlv_cell_q[32];

endmodule

// File: tb/tb_ring_node.sv
// Directed testbench for ring_node with hand-computed expectations.
module tb_ring_node;

    logic        clk = 1'b0;
    logic        rst;
    logic [32:0] cell_id;
    logic [96:0] loc_pos_in, loc_vel_in, ring_pos_in, ring_vel_in;
    logic [32:0] loc_cell_in, ring_cell_in;
    logic [96:0] ring_pos_out, ring_vel_out, dlv_pos, dlv_vel;
    logic [32:0] ring_cell_out, dlv_cell;
    logic        full, idle, overflow;
    logic [15:0] dlv_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [96:0] NW = {1'b1, 96'd0};
    localparam logic [32:0] NC = {1'b1, 32'd0};

    ring_node #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .cell_id(cell_id),
        .loc_pos_in(loc_pos_in), .loc_vel_in(loc_vel_in), .loc_cell_in(loc_cell_in),
        .ring_pos_in(ring_pos_in), .ring_vel_in(ring_vel_in), .ring_cell_in(ring_cell_in),
        .ring_pos_out(ring_pos_out), .ring_vel_out(ring_vel_out), .ring_cell_out(ring_cell_out),
        .dlv_pos(dlv_pos), .dlv_vel(dlv_vel), .dlv_cell(dlv_cell),
        .full(full), .idle(idle), .overflow(overflow), .dlv_cnt(dlv_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [96:0] mk_pos(input int k);
        return {1'b0, 32'(k), 32'hCAFE_0000, 32'(k)};
    endfunction

    function automatic logic [96:0] mk_vel(input int k);
        return {1'b0, 32'hBEEF_0000, 32'(k), ~32'(k)};
    endfunction

    function automatic logic [32:0] mk_cell(input int c);
        return {1'b0, 32'(c)};
    endfunction

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ring_set(input int c, input int k);
        ring_pos_in = mk_pos(k); ring_vel_in = mk_vel(k); ring_cell_in = mk_cell(c);
    endtask

    task automatic ring_null();
        ring_pos_in = NW; ring_vel_in = NW; ring_cell_in = NC;
    endtask

    task automatic loc_set(input int c, input int k);
        loc_pos_in = mk_pos(k); loc_vel_in = mk_vel(k); loc_cell_in = mk_cell(c);
    endtask

    task automatic loc_null();
        loc_pos_in = NW; loc_vel_in = NW; loc_cell_in = NC;
    endtask

    // Checks one packet emerging on the ring output.
    task automatic expect_ring(input string tag, input int c, input int k);
        check({tag, ".cell"}, 128'(ring_cell_out), 128'(mk_cell(c)));
        check({tag, ".pos"},  128'(ring_pos_out),  128'(mk_pos(k)));
        check({tag, ".vel"},  128'(ring_vel_out),  128'(mk_vel(k)));
    endtask

    initial begin
        rst = 1'b1; cell_id = mk_cell(5);
        ring_null(); loc_null();
        step(); step();
        check("rst_ring_cell", 128'(ring_cell_out), 128'(NC));
        check("rst_ring_pos",  128'(ring_pos_out),  128'(NW));
        check("rst_dlv_cell",  128'(dlv_cell),      128'(NC));
        check("rst_dlv_vel",   128'(dlv_vel),       128'(NW));
        check("rst_overflow",  128'(overflow),      128'(0));
        check("rst_dlv_cnt",   128'(dlv_cnt),       128'(0));
        check("rst_full",      128'(full),          128'(0));
        check("rst_idle",      128'(idle),          128'(1));
        rst = 1'b0;

        // Delivery to this cell
        ring_set(5, 1); step(); ring_null();
        check("dlv_cell", 128'(dlv_cell), 128'(mk_cell(5)));
        check("dlv_pos",  128'(dlv_pos),  128'(mk_pos(1)));
        check("dlv_vel",  128'(dlv_vel),  128'(mk_vel(1)));
        check("dlv_ring_null", 128'(ring_cell_out), 128'(NC));
        check("dlv_cnt1", 128'(dlv_cnt), 128'(1));

        // Forwarding
        ring_set(7, 2); step(); ring_null();
        expect_ring("fwd", 7, 2);
        check("fwd_dlv_null", 128'(dlv_cell), 128'(NC));
        check("fwd_dlv_cnt",  128'(dlv_cnt),  128'(1));

        // Packet with a null field is ignored even if addressed here
        ring_set(5, 3); ring_pos_in = NW; step(); ring_null();
        check("nullfld_dlv",  128'(dlv_cell),      128'(NC));
        check("nullfld_ring", 128'(ring_cell_out), 128'(NC));
        check("nullfld_cnt",  128'(dlv_cnt),       128'(1));

        // Local injection: 2-cycle latency, then idle
        loc_set(3, 4); step(); loc_null();
        check("inj_not_yet", 128'(ring_cell_out), 128'(NC));
        check("inj_busy",    128'(idle),          128'(0));
        step();
        expect_ring("inj", 3, 4);
        step();
        check("inj_gone", 128'(ring_cell_out), 128'(NC));
        check("inj_idle", 128'(idle),          128'(1));

        // Continuous ring traffic, 5 local packets (one addressed to self)
        for (int i = 0; i < 5; i++) begin
            ring_set(7, 100 + i);
            loc_set((i == 1) ? 5 : 10 + i, 10 + i);
            if (i == 4) check("ovf_full_before", 128'(full), 128'(1));
            step();
            expect_ring($sformatf("ovf_fwd%0d", i), 7, 100 + i);
        end
        check("ovf_flag", 128'(overflow), 128'(1));
        check("ovf_full", 128'(full),     128'(1));
        ring_null(); loc_null();
        step(); expect_ring("drain0", 10, 10);
        check("drain_full0", 128'(full), 128'(0));
        step(); expect_ring("drain1", 5, 11);
        check("drain_self_nodlv", 128'(dlv_cell), 128'(NC));
        step(); expect_ring("drain2", 12, 12);
        step(); expect_ring("drain3", 13, 13);
        step();
        check("drain_end",  128'(ring_cell_out), 128'(NC));
        check("ovf_sticky", 128'(overflow),      128'(1));
        check("drain_cnt",  128'(dlv_cnt),       128'(1));

        // Simultaneous push and pop at count 2
        ring_set(7, 200); loc_set(20, 20); step();
        ring_set(7, 201); loc_set(21, 21); step();
        ring_null(); loc_set(22, 22); step();
        expect_ring("pp0", 20, 20);
        loc_set(23, 23); step();
        expect_ring("pp1", 21, 21);
        loc_null(); step();
        expect_ring("pp2", 22, 22);
        step();
        expect_ring("pp3", 23, 23);
        step();
        check("pp_end",  128'(ring_cell_out), 128'(NC));
        check("pp_idle", 128'(idle),          128'(1));

        // Reset with 3 buffered packets, inputs active during reset
        for (int i = 0; i < 3; i++) begin
            ring_set(7, 300 + i); loc_set(30 + i, 30 + i); step();
        end
        ring_set(5, 310); loc_set(34, 34); rst = 1'b1; step();
        check("mrst_ring", 128'(ring_cell_out), 128'(NC));
        check("mrst_dlv",  128'(dlv_cell),      128'(NC));
        check("mrst_full", 128'(full),          128'(0));
        check("mrst_ovf",  128'(overflow),      128'(0));
        check("mrst_cnt",  128'(dlv_cnt),       128'(0));
        rst = 1'b0; ring_null(); loc_null();
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("mrst_quiet%0d", i), 128'(ring_cell_out), 128'(NC));
        end
        check("mrst_idle", 128'(idle), 128'(1));

        // First local packet after reset appears two cycles later
        loc_set(40, 40); step(); loc_null();
        check("post_rst_wait", 128'(ring_cell_out), 128'(NC));
        step();
        expect_ring("post_rst", 40, 40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
